clock_set_ctrl: RTL and testbench

- Front-panel controller for the digital clock. Turns four single-cycle button pulses into the display mode select and a field-by-field edit sequence (hour, then minute, then second).
- On commit it issues a one-cycle load strobe with the edited value to exactly one target: the real-time counter, the alarm registers or the timer preset.
- Sits between the button synchroniser and the clock core, and owns mode_sel for the whole design.

---
 rtl/clock_set_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Front-panel set controller: display mode select, hour/minute/second edit
// sequence and one-cycle commit strobes to the RTC, alarm or timer preset.
module clock_set_ctrl #(
  parameter int IDLE_TIMEOUT = 30,
  parameter int TO_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [1:0] mode_sel,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic [4:0] set_hr,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       rtc_load,
  output logic       alarm_load,
  output logic       timer_load
);

  typedef enum logic [2:0] {
    VIEW     = 3'd0,
    EDIT_HR  = 3'd1,
    EDIT_MIN = 3'd2,
    EDIT_SEC = 3'd3,
    COMMIT   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_RTC   = 2'b00;
  localparam logic [1:0] MODE_SW    = 2'b01;
  localparam logic [1:0] MODE_TIMER = 2'b10;
  localparam logic [1:0] MODE_ALARM = 2'b11;
  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(IDLE_TIMEOUT);

  state_t          state, state_nx;
  logic [1:0]      mode_nx, target, target_nx;
  logic [4:0]      hr_nx, al_hr, al_hr_nx, tm_hr, tm_hr_nx, hr_cap;
  logic [5:0]      min_nx, sec_nx, al_min, al_min_nx, al_sec, al_sec_nx;
  logic [5:0]      tm_min, tm_min_nx, tm_sec, tm_sec_nx;
  logic [TO_W-1:0] idle_cnt, idle_nx, idle_inc;
  logic            blink_nx, one_step;

  // Modular field arithmetic; out-of-range inputs collapse into range.
  function automatic logic [4:0] hr_up(input logic [4:0] v);
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] hr_down(input logic [4:0] v);
    return (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] ms_up(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] ms_down(input logic [5:0] v);
    return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
  endfunction

  assign hr_cap   = (cur_hr > 5'd23) ? 5'd23 : cur_hr;
  assign idle_inc = idle_cnt + 1'b1;
  assign one_step = btn_inc ^ btn_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= VIEW;
      mode_sel <= MODE_RTC;
      target   <= MODE_RTC;
      set_hr   <= '0;
      set_min  <= '0;
      set_sec  <= '0;
      al_hr    <= '0;
      al_min   <= '0;
      al_sec   <= '0;
      tm_hr    <= '0;
      tm_min   <= '0;
      tm_sec   <= '0;
      idle_cnt <= '0;
      blink    <= 1'b0;
    end else begin
      state    <= state_nx;
      mode_sel <= mode_nx;
      target   <= target_nx;
      set_hr   <= hr_nx;
      set_min  <= min_nx;
      set_sec  <= sec_nx;
      al_hr    <= al_hr_nx;
      al_min   <= al_min_nx;
      al_sec   <= al_sec_nx;
      tm_hr    <= tm_hr_nx;
      tm_min   <= tm_min_nx;
      tm_sec   <= tm_sec_nx;
      idle_cnt <= idle_nx;
      blink    <= blink_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mode_nx   = mode_sel;
    target_nx = target;
    hr_nx     = set_hr;
    min_nx    = set_min;
    sec_nx    = set_sec;
    al_hr_nx  = al_hr;
    al_min_nx = al_min;
    al_sec_nx = al_sec;
    tm_hr_nx  = tm_hr;
    tm_min_nx = tm_min;
    tm_sec_nx = tm_sec;
    idle_nx   = idle_cnt;
    blink_nx  = blink;
    case (state)
      VIEW: begin
        blink_nx = 1'b0;
        if (btn_mode) begin
          mode_nx = mode_sel + 2'd1;
        end else if (btn_set && mode_sel != MODE_SW) begin
          target_nx = mode_sel;
          state_nx  = EDIT_HR;
          idle_nx   = '0;
          blink_nx  = 1'b1;
          case (mode_sel)
            MODE_TIMER: begin hr_nx = tm_hr; min_nx = tm_min; sec_nx = tm_sec; end
            MODE_ALARM: begin hr_nx = al_hr; min_nx = al_min; sec_nx = al_sec; end
            default:    begin hr_nx = hr_cap; min_nx = cur_min; sec_nx = cur_sec; end
          endcase
        end
      end
      EDIT_HR, EDIT_MIN, EDIT_SEC: begin
        if (btn_mode) begin
          state_nx = VIEW;
          idle_nx  = '0;
          blink_nx = 1'b0;
        end else if (btn_set) begin
          idle_nx = '0;
          case (state)
            EDIT_HR:  state_nx = EDIT_MIN;
            EDIT_MIN: state_nx = EDIT_SEC;
            default: begin
              state_nx = COMMIT;
              blink_nx = 1'b0;
            end
          endcase
        end else if (btn_inc || btn_dec) begin
          // Simultaneous inc+dec only counts as activity.
          idle_nx = '0;
          if (one_step) begin
            blink_nx = 1'b1;
            case (state)
              EDIT_HR:  hr_nx  = btn_inc ? hr_up(set_hr)   : hr_down(set_hr);
              EDIT_MIN: min_nx = btn_inc ? ms_up(set_min)  : ms_down(set_min);
              default:  sec_nx = btn_inc ? ms_up(set_sec)  : ms_down(set_sec);
            endcase
          end
        end else if (tick_1hz) begin
          if (idle_inc == TIMEOUT_VAL) begin
            state_nx = VIEW;
            idle_nx  = '0;
            blink_nx = 1'b0;
          end else begin
            idle_nx  = idle_inc;
            blink_nx = ~blink;
          end
        end
      end
      COMMIT: begin
        state_nx = VIEW;
        blink_nx = 1'b0;
        if (target == MODE_ALARM) begin
          al_hr_nx = set_hr; al_min_nx = set_min; al_sec_nx = set_sec;
        end else if (target == MODE_TIMER) begin
          tm_hr_nx = set_hr; tm_min_nx = set_min; tm_sec_nx = set_sec;
        end
      end
      default: begin
        state_nx = VIEW;
        blink_nx = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (state)
      EDIT_HR:  edit_field = 2'd1;
      EDIT_MIN: edit_field = 2'd2;
      EDIT_SEC: edit_field = 2'd3;
      default:  edit_field = 2'd0;
    endcase
  end

  assign rtc_load   = (state == COMMIT) && (target == MODE_RTC);
  assign alarm_load = (state == COMMIT) && (target == MODE_ALARM);
  assign timer_load = (state == COMMIT) && (target == MODE_TIMER);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: mode stepping, RTC/alarm/timer edits,
// idle timeout, simultaneous buttons and mid-edit reset.
module tb_clock_set_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_set = 1'b0;
  logic       btn_inc = 1'b0, btn_dec = 1'b0;
  logic [4:0] cur_hr = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic [1:0] mode_sel, edit_field;
  logic       blink, rtc_load, alarm_load, timer_load;
  logic [4:0] set_hr;
  logic [5:0] set_min, set_sec;
  int checks = 0;
  int errors = 0;

  clock_set_ctrl #(.IDLE_TIMEOUT(30), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
    .mode_sel(mode_sel), .edit_field(edit_field), .blink(blink),
    .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
    .rtc_load(rtc_load), .alarm_load(alarm_load), .timer_load(timer_load)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given button/tick levels; outputs sampled 1ns after the edge.
  task automatic cyc(input logic m, input logic s, input logic i, input logic d, input logic t);
    btn_mode = m; btn_set = s; btn_inc = i; btn_dec = d; tick_1hz = t;
    @(posedge clk); #1;
    btn_mode = 0; btn_set = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cyc(0, 0, 0, 0, 0); rst = 1'b0;
    checks++; if (mode_sel !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode_sel); end
    checks++; if (edit_field !== 2'd0) begin errors++; $display("FAIL reset_field got %0d want 0", edit_field); end
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink got %0d want 0", blink); end
    checks++; if ({set_hr, set_min, set_sec} !== 17'd0) begin errors++; $display("FAIL reset_set got %0d:%0d:%0d want 0:0:0", set_hr, set_min, set_sec); end
    checks++; if ({rtc_load, alarm_load, timer_load} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {rtc_load, alarm_load, timer_load}); end
  endtask

  task automatic test_mode_cycle;
    logic [1:0] exp_mode [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 0, 0);
      checks++; if (mode_sel !== exp_mode[k]) begin errors++; $display("FAIL mode_step%0d got %0d want %0d", k, mode_sel, exp_mode[k]); end
      checks++; if (edit_field !== 2'd0 || {rtc_load, alarm_load, timer_load} !== 3'b000) begin
        errors++; $display("FAIL mode_step%0d_quiet got field %0d strobes %b want 0 000", k, edit_field, {rtc_load, alarm_load, timer_load}); end
    end
  endtask

  task automatic test_stopwatch_noedit;
    cyc(0, 1, 0, 0, 0);
    checks++; if (edit_field !== 2'd0 || mode_sel !== 2'd1) begin errors++; $display("FAIL sw_noedit got field %0d mode %0d want 0 1", edit_field, mode_sel); end
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    checks++; if (mode_sel !== 2'd0) begin errors++; $display("FAIL back_to_rtc got %0d want 0", mode_sel); end
  endtask

  task automatic test_clamp;
    cur_hr = 5'd30; cur_min = 6'd5; cur_sec = 6'd7;
    cyc(0, 1, 0, 0, 0);
    checks++; if (set_hr !== 5'd23 || edit_field !== 2'd1) begin errors++; $display("FAIL clamp_hr got hr %0d field %0d want 23 1", set_hr, edit_field); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (edit_field !== 2'd0 || mode_sel !== 2'd0) begin errors++; $display("FAIL clamp_abort got field %0d mode %0d want 0 0", edit_field, mode_sel); end
  endtask

  task automatic test_rtc_edit;
    cur_hr = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    cyc(0, 1, 0, 0, 0);
    checks++; if (edit_field !== 2'd1 || blink !== 1'b1) begin errors++; $display("FAIL rtc_enter got field %0d blink %0d want 1 1", edit_field, blink); end
    checks++; if (set_hr !== 5'd12 || set_min !== 6'd34 || set_sec !== 6'd56) begin errors++; $display("FAIL rtc_capture got %0d:%0d:%0d want 12:34:56", set_hr, set_min, set_sec); end
    for (int k = 0; k < 12; k++) cyc(0, 0, 1, 0, 0);
    checks++; if (set_hr !== 5'd0) begin errors++; $display("FAIL rtc_hr_wrap got %0d want 0", set_hr); end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    checks++; if (set_min !== 6'd33 || edit_field !== 2'd2) begin errors++; $display("FAIL rtc_min_dec got min %0d field %0d want 33 2", set_min, edit_field); end
    cyc(0, 1, 0, 0, 0);
    checks++; if (edit_field !== 2'd3 || rtc_load !== 1'b0) begin errors++; $display("FAIL rtc_sec_field got field %0d load %0d want 3 0", edit_field, rtc_load); end
    cyc(0, 1, 0, 0, 0);
    checks++; if ({rtc_load, alarm_load, timer_load} !== 3'b100) begin errors++; $display("FAIL rtc_commit_strobe got %b want 100", {rtc_load, alarm_load, timer_load}); end
    checks++; if (set_hr !== 5'd0 || set_min !== 6'd33 || set_sec !== 6'd56) begin errors++; $display("FAIL rtc_commit_val got %0d:%0d:%0d want 0:33:56", set_hr, set_min, set_sec); end
    cyc(0, 1, 0, 0, 0);
    checks++; if (rtc_load !== 1'b0 || edit_field !== 2'd0) begin errors++; $display("FAIL rtc_after_commit got load %0d field %0d want 0 0", rtc_load, edit_field); end
  endtask

  task automatic test_alarm_edit;
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    checks++; if (mode_sel !== 2'd3) begin errors++; $display("FAIL alarm_mode got %0d want 3", mode_sel); end
    cyc(0, 1, 0, 0, 0);
    checks++; if ({set_hr, set_min, set_sec} !== 17'd0) begin errors++; $display("FAIL alarm_shadow_init got %0d:%0d:%0d want 0:0:0", set_hr, set_min, set_sec); end
    cyc(0, 0, 0, 1, 0);
    checks++; if (set_hr !== 5'd23) begin errors++; $display("FAIL alarm_hr_wrap got %0d want 23", set_hr); end
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    checks++; if ({rtc_load, alarm_load, timer_load} !== 3'b010) begin errors++; $display("FAIL alarm_commit_strobe got %b want 010", {rtc_load, alarm_load, timer_load}); end
    checks++; if (set_hr !== 5'd23 || set_min !== 6'd0 || set_sec !== 6'd0) begin errors++; $display("FAIL alarm_commit_val got %0d:%0d:%0d want 23:0:0", set_hr, set_min, set_sec); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (mode_sel !== 2'd3 || alarm_load !== 1'b0) begin errors++; $display("FAIL commit_ignores_btn got mode %0d load %0d want 3 0", mode_sel, alarm_load); end
    cur_hr = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
    cyc(0, 1, 0, 0, 0);
    checks++; if (set_hr !== 5'd23 || set_min !== 6'd0 || set_sec !== 6'd0 || edit_field !== 2'd1) begin
      errors++; $display("FAIL alarm_reload got %0d:%0d:%0d field %0d want 23:0:0 1", set_hr, set_min, set_sec, edit_field); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (edit_field !== 2'd0 || mode_sel !== 2'd3 || alarm_load !== 1'b0) begin
      errors++; $display("FAIL alarm_abort got field %0d mode %0d load %0d want 0 3 0", edit_field, mode_sel, alarm_load); end
  endtask

  task automatic test_timeout;
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    checks++; if (edit_field !== 2'd2 || mode_sel !== 2'd2) begin errors++; $display("FAIL to_enter got field %0d mode %0d want 2 2", edit_field, mode_sel); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_toggle got %0d want 0", blink); end
    for (int k = 0; k < 28; k++) cyc(0, 0, 0, 0, 1);
    checks++; if (edit_field !== 2'd2) begin errors++; $display("FAIL to_29 got field %0d want 2", edit_field); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (edit_field !== 2'd0 || mode_sel !== 2'd2 || timer_load !== 1'b0) begin
      errors++; $display("FAIL to_30 got field %0d mode %0d load %0d want 0 2 0", edit_field, mode_sel, timer_load); end
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 29; k++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    checks++; if (edit_field !== 2'd2 || set_min !== 6'd1 || blink !== 1'b1) begin
      errors++; $display("FAIL to_btn_wins got field %0d min %0d blink %0d want 2 1 1", edit_field, set_min, blink); end
    for (int k = 0; k < 29; k++) cyc(0, 0, 0, 0, 1);
    checks++; if (edit_field !== 2'd2) begin errors++; $display("FAIL to_restart29 got field %0d want 2", edit_field); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (edit_field !== 2'd0 || timer_load !== 1'b0) begin errors++; $display("FAIL to_restart30 got field %0d load %0d want 0 0", edit_field, timer_load); end
  endtask

  task automatic test_inc_dec_same;
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    checks++; if (edit_field !== 2'd3 || set_sec !== 6'd0) begin errors++; $display("FAIL sec_enter got field %0d sec %0d want 3 0", edit_field, set_sec); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    checks++; if (set_sec !== 6'd1) begin errors++; $display("FAIL inc_dec_same got %0d want 1", set_sec); end
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
    checks++; if (set_sec !== 6'd59) begin errors++; $display("FAIL sec_wrap_down got %0d want 59", set_sec); end
    cyc(0, 0, 1, 0, 0);
    checks++; if (set_sec !== 6'd0) begin errors++; $display("FAIL sec_wrap_up got %0d want 0", set_sec); end
    cyc(1, 1, 0, 0, 0);
    checks++; if (edit_field !== 2'd0 || mode_sel !== 2'd2 || {rtc_load, alarm_load, timer_load} !== 3'b000) begin
      errors++; $display("FAIL mode_beats_set got field %0d mode %0d strobes %b want 0 2 000", edit_field, mode_sel, {rtc_load, alarm_load, timer_load}); end
    cyc(0, 0, 0, 0, 0);
    checks++; if ({rtc_load, alarm_load, timer_load} !== 3'b000) begin errors++; $display("FAIL no_late_strobe got %b want 000", {rtc_load, alarm_load, timer_load}); end
  endtask

  task automatic test_rst_mid_edit;
    cyc(0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0);
    checks++; if (edit_field !== 2'd1 || set_hr !== 5'd1) begin errors++; $display("FAIL pre_rst got field %0d hr %0d want 1 1", edit_field, set_hr); end
    rst = 1'b1; cyc(0, 0, 0, 0, 0); rst = 1'b0;
    checks++; if (mode_sel !== 2'd0 || edit_field !== 2'd0 || blink !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl got mode %0d field %0d blink %0d want 0 0 0", mode_sel, edit_field, blink); end
    checks++; if ({set_hr, set_min, set_sec} !== 17'd0 || {rtc_load, alarm_load, timer_load} !== 3'b000) begin
      errors++; $display("FAIL rst_data got %0d:%0d:%0d strobes %b want 0:0:0 000", set_hr, set_min, set_sec, {rtc_load, alarm_load, timer_load}); end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_stopwatch_noedit();
    test_clamp();
    test_rtc_edit();
    test_alarm_edit();
    test_timeout();
    test_inc_dec_same();
    test_rst_mid_edit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
